// File: rtl/spi_reg_ctrl_pkg.sv
// Shared constants and types for the register-access sequencer and its spi_drive user port.
package spi_reg_ctrl_pkg;

    localparam int FRAME_W = 9;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_REQ,
        ST_HDR_WAIT,
        ST_DAT_REQ,
        ST_DAT_WAIT
    } state_t;

    // Reads send an all-zero dummy data frame so the slave can shift out the register value.
    function automatic logic [FRAME_W-1:0] dat_frame(input logic rw, input logic [DATA_W-1:0] wdata);
        return (rw == RW_READ) ? '0 : FRAME_W'(wdata);
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Request/response bus plus the spi_drive user port of the register sequencer.
interface spi_reg_ctrl_if;
    import spi_reg_ctrl_pkg::*;

    logic              req_valid;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_done;
    logic              err;

    logic [FRAME_W-1:0] spi_data;
    logic               spi_valid;
    logic               spi_ready;
    logic [FRAME_W-1:0] spi_rdata;
    logic               spi_rvalid;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rd_data, rd_valid, wr_done, err,
        input  spi_data, spi_valid,
        output spi_ready, spi_rdata, spi_rvalid
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rd_data, rd_valid, wr_done, err,
        output spi_data, spi_valid,
        input  spi_ready, spi_rdata, spi_rvalid
    );

endinterface

// File: rtl/spi_reg_ctrl_timeout_cnt.sv
// Per-frame watchdog: down-counter reloaded on clear, expires when it reaches terminal count while enabled.
module spi_reg_ctrl_timeout_cnt #(
    parameter int P_TIMEOUT_CYC = 1000
) (
    input  logic iclk,
    input  logic irst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (P_TIMEOUT_CYC > 2) ? $clog2(P_TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(P_TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] remain;

    always_ff @(posedge iclk) begin
        if (irst || clr) begin
            remain <= LOAD;
        end else if (en && (remain != '0)) begin
            remain <= remain - 1'b1;
        end
    end

    // Terminal count corresponds to P_TIMEOUT_CYC-1 cycles elapsed in the current state.
    assign expire = en && (remain == '0);

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer: turns one read/write request into a header and a data frame for spi_drive.
// state       | meaning
// ST_IDLE     | ready for a request
// ST_HDR_REQ  | offering {rw,addr} frame to spi_drive
// ST_HDR_WAIT | header frame in flight, returned data discarded
// ST_DAT_REQ  | offering write data (or dummy zeros on read)
// ST_DAT_WAIT | data frame in flight, capture read byte on completion
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int P_TIMEOUT_CYC = 1000
) (
    input  logic           iclk,
    input  logic           irst,
    spi_reg_ctrl_if.slave  bus
);

    state_t            state;
    logic              lat_rw;
    logic [DATA_W-1:0] lat_wdata;
    logic              adv;
    logic              tmr_en;
    logic              tmr_clr;
    logic              tmr_exp;

    always_comb begin
        adv = 1'b0;
        case (state)
            ST_IDLE:                  adv = bus.req_valid & bus.req_ready;
            ST_HDR_REQ, ST_DAT_REQ:   adv = bus.spi_valid & bus.spi_ready;
            ST_HDR_WAIT, ST_DAT_WAIT: adv = bus.spi_rvalid;
            default:                  adv = 1'b0;
        endcase
    end

    assign tmr_en  = (state != ST_IDLE);
    assign tmr_clr = !tmr_en || adv;

    spi_reg_ctrl_timeout_cnt #(
        .P_TIMEOUT_CYC (P_TIMEOUT_CYC)
    ) u_tmo (
        .iclk   (iclk),
        .irst   (irst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_exp)
    );

    always_ff @(posedge iclk) begin
        if (irst) begin
            state         <= ST_IDLE;
            lat_rw        <= RW_WRITE;
            lat_wdata     <= '0;
            bus.req_ready <= 1'b1;
            bus.rd_data   <= '0;
            bus.rd_valid  <= 1'b0;
            bus.wr_done   <= 1'b0;
            bus.err       <= 1'b0;
            bus.spi_data  <= '0;
            bus.spi_valid <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            bus.wr_done  <= 1'b0;
            bus.err      <= 1'b0;

            // Abort wins over a coincident handshake so a stuck frame never half-completes.
            if (tmr_exp) begin
                state         <= ST_IDLE;
                bus.spi_valid <= 1'b0;
                bus.err       <= 1'b1;
                bus.req_ready <= 1'b1;
            end else if (adv) begin
                case (state)
                    ST_IDLE: begin
                        lat_rw        <= bus.req_rw;
                        lat_wdata     <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        bus.spi_data  <= {bus.req_rw, bus.req_addr};
                        bus.spi_valid <= 1'b1;
                        state         <= ST_HDR_REQ;
                    end
                    ST_HDR_REQ: begin
                        bus.spi_valid <= 1'b0;
                        state         <= ST_HDR_WAIT;
                    end
                    ST_HDR_WAIT: begin
                        bus.spi_data  <= dat_frame(lat_rw, lat_wdata);
                        bus.spi_valid <= 1'b1;
                        state         <= ST_DAT_REQ;
                    end
                    ST_DAT_REQ: begin
                        bus.spi_valid <= 1'b0;
                        state         <= ST_DAT_WAIT;
                    end
                    ST_DAT_WAIT: begin
                        if (lat_rw == RW_READ) begin
                            bus.rd_data  <= bus.spi_rdata[DATA_W-1:0];
                            bus.rd_valid <= 1'b1;
                        end else begin
                            bus.wr_done  <= 1'b1;
                        end
                        bus.req_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                    default: begin
                        bus.spi_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl with a behavioural model of the spi_drive user port.
module tb_spi_reg_ctrl;
    import spi_reg_ctrl_pkg::*;

    localparam int TMO = 16;
    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_RD  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    logic iclk = 1'b0;
    logic irst = 1'b1;

    spi_reg_ctrl_if bus();

    spi_reg_ctrl #(.P_TIMEOUT_CYC(TMO)) dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic [1:0]        kind;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t              resp_q[$];
    logic [FRAME_W-1:0] frame_q[$];
    logic [FRAME_W-1:0] miso_q[$];

    int vectors = 0;
    int miscompares = 0;

    int bfm_lat = 4;
    int rdy_dly = 0;
    bit rv_en = 1'b1;

    int cyc = 0;
    int frames_seen = 0;
    int acc_count = 0;
    int stall = 0;
    int last_stall = 0;
    int acc_cyc = 0;
    int err_cyc = 0;
    int ready_viol = 0;
    int stab_viol = 0;
    bit in_seq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // spi_drive user-port model: one frame at a time, rvalid bfm_lat cycles after accept.
    initial begin : bfm
        bit busy;
        int cnt;
        int wait_cnt;
        logic n_ready, n_rvalid;
        logic [FRAME_W-1:0] n_rdata;
        busy = 1'b0; cnt = 0; wait_cnt = 0;
        bus.spi_ready  = 1'b0;
        bus.spi_rvalid = 1'b0;
        bus.spi_rdata  = '0;
        forever begin
            @(negedge iclk);
            n_rvalid = 1'b0;
            n_rdata  = '0;
            if (irst) begin
                busy = 1'b0;
                wait_cnt = 0;
                miso_q.delete();
            end else if (bus.spi_valid && bus.spi_ready) begin
                busy = 1'b1;
                cnt = bfm_lat;
                wait_cnt = 0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 1'b0;
                    if (rv_en) begin
                        n_rvalid = 1'b1;
                        n_rdata  = (miso_q.size() != 0) ? miso_q.pop_front() : '0;
                    end
                end
            end else if (bus.spi_valid) begin
                wait_cnt++;
            end
            n_ready = !busy && (wait_cnt >= rdy_dly);
            @(posedge iclk);
            #1;
            bus.spi_ready  = n_ready;
            bus.spi_rvalid = n_rvalid;
            bus.spi_rdata  = n_rdata;
        end
    end

    initial begin : monitor
        logic pv, pa, acc;
        logic [FRAME_W-1:0] pd;
        logic [1:0] k;
        logic [DATA_W-1:0] d;
        int npulse;
        resp_t r;
        pv = 1'b0; pa = 1'b0; pd = '0;
        forever begin
            @(negedge iclk);
            cyc++;
            acc = bus.spi_valid & bus.spi_ready;
            if (irst) begin
                pv = 1'b0; pa = 1'b0; stall = 0; in_seq = 1'b0;
            end else begin
                if (pv && !pa && (!bus.spi_valid || bus.spi_data !== pd)) stab_viol++;
                if (acc) begin
                    frames_seen++;
                    last_stall = stall;
                    stall = 0;
                    acc_cyc = cyc;
                    if (frame_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL frame: unexpected frame 0x%0h", bus.spi_data);
                    end else begin
                        chk("frame", bus.spi_data, frame_q.pop_front());
                    end
                end else if (bus.spi_valid) begin
                    stall++;
                end
                npulse = int'(bus.rd_valid) + int'(bus.wr_done) + int'(bus.err);
                if (npulse != 0) begin
                    k = bus.err ? K_ERR : (bus.rd_valid ? K_RD : K_WR);
                    d = bus.rd_valid ? bus.rd_data : '0;
                    if (bus.err) err_cyc = cyc;
                    chk("pulse_count", npulse, 1);
                    chk("ready_at_done", bus.req_ready, 1);
                    if (resp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL resp: unexpected pulse kind %0d data 0x%0h", k, d);
                    end else begin
                        r = resp_q.pop_front();
                        chk("resp_kind", k, r.kind);
                        chk("resp_data", d, r.data);
                    end
                    in_seq = 1'b0;
                end else if (in_seq && bus.req_ready) begin
                    ready_viol++;
                end
                if (bus.req_valid && bus.req_ready) begin
                    acc_count++;
                    in_seq = 1'b1;
                end
            end
            pv = bus.spi_valid; pa = acc; pd = bus.spi_data;
        end
    end

    // mode 0: normal completion; 1: header only then timeout; 2: aborted by reset
    task automatic do_req(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [8:0] exp_hdr, input logic [8:0] exp_dat,
                          input logic [8:0] dat_miso, input logic [7:0] exp_rd, input int mode);
        resp_t r;
        int n;
        frame_q.push_back(exp_hdr);
        if (mode != 1) begin
            frame_q.push_back(exp_dat);
            miso_q.push_back(9'h1C3);
            miso_q.push_back(dat_miso);
        end
        if (mode == 0) begin
            r.kind = rw ? K_RD : K_WR;
            r.data = rw ? exp_rd : 8'h00;
            resp_q.push_back(r);
        end else if (mode == 1) begin
            r.kind = K_ERR;
            r.data = 8'h00;
            resp_q.push_back(r);
        end
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge iclk);
            n++;
        end while (!bus.req_ready && n < 100);
        if (!bus.req_ready) bound_fail("req_accept");
        @(posedge iclk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge iclk);
            n++;
        end while (!(resp_q.size() == 0 && frame_q.size() == 0 && bus.req_ready) && n < 300);
        if (n >= 300) bound_fail(name);
        repeat (3) @(negedge iclk);
        @(posedge iclk);
        #1;
    endtask

    initial begin : stim
        logic       b_rw[3];
        logic [7:0] b_addr[3];
        logic [7:0] b_wdata[3];
        resp_t r;
        int a0, f0, n;

        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        irst = 1'b1;
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_spi_valid", bus.spi_valid, 0);
        chk("rst_spi_data", bus.spi_data, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_wr_done", bus.wr_done, 0);
        chk("rst_err", bus.err, 0);
        @(posedge iclk);
        #1;
        irst = 1'b0;
        repeat (2) @(posedge iclk);
        #1;

        // write 0x12 <- 0xA5
        do_req(1'b0, 8'h12, 8'hA5, 9'h012, 9'h0A5, 9'h000, 8'h00, 0);
        wait_idle("t1_idle");

        // read 0x34, slave returns 0x05A in data frame
        do_req(1'b1, 8'h34, 8'h00, 9'h134, 9'h000, 9'h05A, 8'h5A, 0);
        wait_idle("t2_idle");
        chk("rd_hold", bus.rd_data, 8'h5A);

        // three requests with req_valid held high
        b_rw[0] = 1'b0; b_addr[0] = 8'h01; b_wdata[0] = 8'h11;
        b_rw[1] = 1'b1; b_addr[1] = 8'h02; b_wdata[1] = 8'h00;
        b_rw[2] = 1'b0; b_addr[2] = 8'h03; b_wdata[2] = 8'hFF;
        frame_q.push_back(9'h001); frame_q.push_back(9'h011);
        frame_q.push_back(9'h102); frame_q.push_back(9'h000);
        frame_q.push_back(9'h003); frame_q.push_back(9'h0FF);
        miso_q.push_back(9'h1C3); miso_q.push_back(9'h000);
        miso_q.push_back(9'h1C3); miso_q.push_back(9'h0EE);
        miso_q.push_back(9'h1C3); miso_q.push_back(9'h000);
        r.kind = K_WR; r.data = 8'h00; resp_q.push_back(r);
        r.kind = K_RD; r.data = 8'hEE; resp_q.push_back(r);
        r.kind = K_WR; r.data = 8'h00; resp_q.push_back(r);
        a0 = acc_count;
        bus.req_rw = b_rw[0]; bus.req_addr = b_addr[0]; bus.req_wdata = b_wdata[0];
        bus.req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge iclk);
                n++;
            end while (!bus.req_ready && n < 200);
            if (!bus.req_ready) bound_fail("b2b_accept");
            @(posedge iclk);
            #1;
            if (k < 2) begin
                bus.req_rw = b_rw[k+1]; bus.req_addr = b_addr[k+1]; bus.req_wdata = b_wdata[k+1];
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        wait_idle("t3_idle");
        chk("b2b_accepts", acc_count - a0, 3);
        chk("b2b_ready_low", ready_viol, 0);

        // spi_drive never completes the header: timeout after 16 cycles in HDR_WAIT
        rv_en = 1'b0;
        do_req(1'b0, 8'h56, 8'h3C, 9'h056, 9'h03C, 9'h000, 8'h00, 1);
        wait_idle("t4_idle");
        chk("tmo_cycles", err_cyc - acc_cyc, 17);
        rv_en = 1'b1;
        do_req(1'b0, 8'h78, 8'hC3, 9'h078, 9'h0C3, 9'h000, 8'h00, 0);
        wait_idle("t4b_idle");

        // reset while the data frame of a write is in flight
        f0 = frames_seen;
        do_req(1'b0, 8'h21, 8'h77, 9'h021, 9'h077, 9'h000, 8'h00, 2);
        n = 0;
        while (frames_seen < f0 + 2 && n < 100) begin
            @(posedge iclk);
            n++;
        end
        if (frames_seen < f0 + 2) bound_fail("t5_frames");
        #1;
        irst = 1'b1;
        @(posedge iclk);
        #1;
        irst = 1'b0;
        @(negedge iclk);
        chk("rst5_req_ready", bus.req_ready, 1);
        chk("rst5_spi_valid", bus.spi_valid, 0);
        chk("rst5_spi_data", bus.spi_data, 0);
        chk("rst5_rd_data", bus.rd_data, 0);
        chk("rst5_rd_valid", bus.rd_valid, 0);
        chk("rst5_wr_done", bus.wr_done, 0);
        chk("rst5_err", bus.err, 0);
        repeat (10) @(posedge iclk);
        #1;
        do_req(1'b1, 8'h43, 8'h00, 9'h143, 9'h000, 9'h0C9, 8'hC9, 0);
        wait_idle("t5_idle");

        // ready held off for 7 cycles on each frame
        rdy_dly = 7;
        do_req(1'b0, 8'h9A, 8'h5C, 9'h09A, 9'h05C, 9'h000, 8'h00, 0);
        wait_idle("t6_idle");
        chk("dat_stall", last_stall, 7);
        chk("stable_while_stalled", stab_viol, 0);
        rdy_dly = 0;

        chk("frames_left", frame_q.size(), 0);
        chk("resps_left", resp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
